// File: rtl/dcache_ctrl.sv
// Control FSM for a 2-way, write-back, write-allocate data cache.
// Sweeps all sets after reset, serves hits in two cycles, and handles victim writeback plus line refill on a miss.
module dcache_ctrl #(
    parameter int IDX_W = 8,
    parameter int TAG_W = 20,
    parameter int OFF_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req_i,
    input  logic               cpu_we_i,
    input  logic [31:0]        cpu_addr_i,
    input  logic [31:0]        cpu_wdata_i,
    output logic               cpu_ready_o,
    output logic               cpu_done_o,
    output logic [31:0]        cpu_rdata_o,
    output logic [IDX_W-1:0]   index_o,
    output logic [OFF_W-1:0]   offset_o,
    output logic               w0_tag_en_o,
    output logic               w0_valid_en_o,
    output logic               w0_dirty_en_o,
    output logic               w0_lru_en_o,
    output logic [3:0]         w0_data_en_o,
    output logic               w1_tag_en_o,
    output logic               w1_valid_en_o,
    output logic               w1_dirty_en_o,
    output logic               w1_lru_en_o,
    output logic [3:0]         w1_data_en_o,
    output logic [TAG_W-1:0]   wr_tag_o,
    output logic               wr_valid_o,
    output logic               wr_dirty_o,
    output logic               wr_lru_o,
    output logic [127:0]       wr_data_o,
    input  logic [TAG_W-1:0]   w0_rd_tag_i,
    input  logic               w0_rd_valid_i,
    input  logic               w0_rd_dirty_i,
    input  logic               w0_rd_lru_i,
    input  logic [127:0]       w0_rd_data_i,
    input  logic [TAG_W-1:0]   w1_rd_tag_i,
    input  logic               w1_rd_valid_i,
    input  logic               w1_rd_dirty_i,
    input  logic               w1_rd_lru_i,
    input  logic [127:0]       w1_rd_data_i,
    output logic               mem_rd_req_o,
    output logic [31:0]        mem_rd_addr_o,
    input  logic               mem_rd_valid_i,
    input  logic [127:0]       mem_rd_data_i,
    output logic               mem_wr_req_o,
    output logic [31:0]        mem_wr_addr_o,
    output logic [127:0]       mem_wr_data_o,
    input  logic               mem_wr_ack_i
);

    typedef enum logic [2:0] {INIT, IDLE, LOOKUP, WB, REFILL, FILL} state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   cnt;
    logic [31:0]        req_addr;
    logic               req_we;
    logic [31:0]        req_wdata;
    logic               victim;
    logic [TAG_W-1:0]   vic_tag;
    logic [127:0]       vic_data;
    logic [127:0]       fill_data;

    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [OFF_W-1:0]   req_off;
    logic [1:0]         req_word;
    logic               hit0, hit1;
    logic [127:0]       hit_line;
    logic               vic_valid, vic_dirty;
    logic [127:0]       merged;
    logic               unused_lru;

    function automatic logic [31:0] word_of(input logic [127:0] line, input logic [1:0] sel);
        return line[sel*32 +: 32];
    endfunction

    assign req_tag    = req_addr[31 -: TAG_W];
    assign req_idx    = req_addr[OFF_W +: IDX_W];
    assign req_off    = req_addr[OFF_W-1:0];
    assign req_word   = req_addr[3:2];
    assign hit0       = w0_rd_valid_i && (w0_rd_tag_i == req_tag);
    assign hit1       = w1_rd_valid_i && (w1_rd_tag_i == req_tag);
    assign hit_line   = hit0 ? w0_rd_data_i : w1_rd_data_i;
    // Replacement decision uses way0's LRU bit only; both ways always carry the same value.
    assign vic_valid  = w0_rd_lru_i ? w1_rd_valid_i : w0_rd_valid_i;
    assign vic_dirty  = w0_rd_lru_i ? w1_rd_dirty_i : w0_rd_dirty_i;
    assign unused_lru = w1_rd_lru_i;

    always_comb begin
        merged = fill_data;
        if (req_we) begin
            merged[req_word*32 +: 32] = req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            cnt       <= '0;
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            victim    <= 1'b0;
            vic_tag   <= '0;
            vic_data  <= '0;
            fill_data <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT) begin
                cnt <= cnt + 1'b1;
            end
            if (state == IDLE && cpu_req_i) begin
                req_addr  <= cpu_addr_i;
                req_we    <= cpu_we_i;
                req_wdata <= cpu_wdata_i;
            end
            if (state == LOOKUP) begin
                victim   <= w0_rd_lru_i;
                vic_tag  <= w0_rd_lru_i ? w1_rd_tag_i : w0_rd_tag_i;
                vic_data <= w0_rd_lru_i ? w1_rd_data_i : w0_rd_data_i;
            end
            if (state == REFILL && mem_rd_valid_i) begin
                fill_data <= mem_rd_data_i;
            end
        end
    end

    // Outputs are forced low while reset is held so memory requests drop at once.
    always_comb begin
        state_nx      = state;
        cpu_ready_o   = 1'b0;
        cpu_done_o    = 1'b0;
        cpu_rdata_o   = '0;
        index_o       = '0;
        offset_o      = '0;
        w0_tag_en_o   = 1'b0;
        w0_valid_en_o = 1'b0;
        w0_dirty_en_o = 1'b0;
        w0_lru_en_o   = 1'b0;
        w0_data_en_o  = '0;
        w1_tag_en_o   = 1'b0;
        w1_valid_en_o = 1'b0;
        w1_dirty_en_o = 1'b0;
        w1_lru_en_o   = 1'b0;
        w1_data_en_o  = '0;
        wr_tag_o      = '0;
        wr_valid_o    = 1'b0;
        wr_dirty_o    = 1'b0;
        wr_lru_o      = 1'b0;
        wr_data_o     = '0;
        mem_rd_req_o  = 1'b0;
        mem_rd_addr_o = '0;
        mem_wr_req_o  = 1'b0;
        mem_wr_addr_o = '0;
        mem_wr_data_o = '0;
        if (!rst) begin
            case (state)
                INIT: begin
                    index_o       = cnt;
                    w0_valid_en_o = 1'b1;
                    w0_dirty_en_o = 1'b1;
                    w0_lru_en_o   = 1'b1;
                    w1_valid_en_o = 1'b1;
                    w1_dirty_en_o = 1'b1;
                    w1_lru_en_o   = 1'b1;
                    if (cnt == '1) begin
                        state_nx = IDLE;
                    end
                end
                IDLE: begin
                    cpu_ready_o = 1'b1;
                    index_o     = cpu_addr_i[OFF_W +: IDX_W];
                    offset_o    = cpu_addr_i[OFF_W-1:0];
                    if (cpu_req_i) begin
                        state_nx = LOOKUP;
                    end
                end
                LOOKUP: begin
                    index_o  = req_idx;
                    offset_o = req_off;
                    if (hit0 || hit1) begin
                        cpu_done_o  = 1'b1;
                        cpu_rdata_o = word_of(hit_line, req_word);
                        w0_lru_en_o = 1'b1;
                        w1_lru_en_o = 1'b1;
                        wr_lru_o    = hit0;
                        if (req_we) begin
                            wr_data_o  = {4{req_wdata}};
                            wr_dirty_o = 1'b1;
                            if (hit0) begin
                                w0_dirty_en_o = 1'b1;
                                w0_data_en_o  = 4'b0001 << req_word;
                            end else begin
                                w1_dirty_en_o = 1'b1;
                                w1_data_en_o  = 4'b0001 << req_word;
                            end
                        end
                        state_nx = IDLE;
                    end else if (vic_valid && vic_dirty) begin
                        state_nx = WB;
                    end else begin
                        state_nx = REFILL;
                    end
                end
                WB: begin
                    index_o       = req_idx;
                    offset_o      = req_off;
                    mem_wr_req_o  = 1'b1;
                    mem_wr_addr_o = {vic_tag, req_idx, {OFF_W{1'b0}}};
                    mem_wr_data_o = vic_data;
                    if (mem_wr_ack_i) begin
                        state_nx = REFILL;
                    end
                end
                REFILL: begin
                    index_o       = req_idx;
                    offset_o      = req_off;
                    mem_rd_req_o  = 1'b1;
                    mem_rd_addr_o = {req_addr[31:OFF_W], {OFF_W{1'b0}}};
                    if (mem_rd_valid_i) begin
                        state_nx = FILL;
                    end
                end
                FILL: begin
                    index_o     = req_idx;
                    offset_o    = req_off;
                    wr_tag_o    = req_tag;
                    wr_valid_o  = 1'b1;
                    wr_dirty_o  = req_we;
                    wr_lru_o    = ~victim;
                    wr_data_o   = merged;
                    w0_lru_en_o = 1'b1;
                    w1_lru_en_o = 1'b1;
                    if (victim) begin
                        w1_tag_en_o   = 1'b1;
                        w1_valid_en_o = 1'b1;
                        w1_dirty_en_o = 1'b1;
                        w1_data_en_o  = 4'b1111;
                    end else begin
                        w0_tag_en_o   = 1'b1;
                        w0_valid_en_o = 1'b1;
                        w0_dirty_en_o = 1'b1;
                        w0_data_en_o  = 4'b1111;
                    end
                    cpu_done_o  = 1'b1;
                    cpu_rdata_o = word_of(merged, req_word);
                    state_nx    = IDLE;
                end
                default: state_nx = INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: behavioural way tables and main memory around the controller,
// a vector table of accesses with hand-computed results, plus reset/sweep sequences.
module tb_dcache_ctrl;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req_i = 1'b0;
    logic          cpu_we_i = 1'b0;
    logic [31:0]   cpu_addr_i = '0;
    logic [31:0]   cpu_wdata_i = '0;
    logic          cpu_ready_o, cpu_done_o;
    logic [31:0]   cpu_rdata_o;
    logic [7:0]    index_o;
    logic [3:0]    offset_o;
    logic          w0_tag_en_o, w0_valid_en_o, w0_dirty_en_o, w0_lru_en_o;
    logic          w1_tag_en_o, w1_valid_en_o, w1_dirty_en_o, w1_lru_en_o;
    logic [3:0]    w0_data_en_o, w1_data_en_o;
    logic [19:0]   wr_tag_o;
    logic          wr_valid_o, wr_dirty_o, wr_lru_o;
    logic [127:0]  wr_data_o;
    logic [19:0]   w0_rd_tag_i, w1_rd_tag_i;
    logic          w0_rd_valid_i, w0_rd_dirty_i, w0_rd_lru_i;
    logic          w1_rd_valid_i, w1_rd_dirty_i, w1_rd_lru_i;
    logic [127:0]  w0_rd_data_i, w1_rd_data_i;
    logic          mem_rd_req_o, mem_wr_req_o;
    logic [31:0]   mem_rd_addr_o, mem_wr_addr_o;
    logic          mem_rd_valid_i = 1'b0;
    logic [127:0]  mem_rd_data_i = '0;
    logic [127:0]  mem_wr_data_o;
    logic          mem_wr_ack_i = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_ready_o(cpu_ready_o), .cpu_done_o(cpu_done_o), .cpu_rdata_o(cpu_rdata_o),
        .index_o(index_o), .offset_o(offset_o),
        .w0_tag_en_o(w0_tag_en_o), .w0_valid_en_o(w0_valid_en_o), .w0_dirty_en_o(w0_dirty_en_o),
        .w0_lru_en_o(w0_lru_en_o), .w0_data_en_o(w0_data_en_o),
        .w1_tag_en_o(w1_tag_en_o), .w1_valid_en_o(w1_valid_en_o), .w1_dirty_en_o(w1_dirty_en_o),
        .w1_lru_en_o(w1_lru_en_o), .w1_data_en_o(w1_data_en_o),
        .wr_tag_o(wr_tag_o), .wr_valid_o(wr_valid_o), .wr_dirty_o(wr_dirty_o), .wr_lru_o(wr_lru_o),
        .wr_data_o(wr_data_o),
        .w0_rd_tag_i(w0_rd_tag_i), .w0_rd_valid_i(w0_rd_valid_i), .w0_rd_dirty_i(w0_rd_dirty_i),
        .w0_rd_lru_i(w0_rd_lru_i), .w0_rd_data_i(w0_rd_data_i),
        .w1_rd_tag_i(w1_rd_tag_i), .w1_rd_valid_i(w1_rd_valid_i), .w1_rd_dirty_i(w1_rd_dirty_i),
        .w1_rd_lru_i(w1_rd_lru_i), .w1_rd_data_i(w1_rd_data_i),
        .mem_rd_req_o(mem_rd_req_o), .mem_rd_addr_o(mem_rd_addr_o),
        .mem_rd_valid_i(mem_rd_valid_i), .mem_rd_data_i(mem_rd_data_i),
        .mem_wr_req_o(mem_wr_req_o), .mem_wr_addr_o(mem_wr_addr_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_wr_ack_i(mem_wr_ack_i)
    );

    // Way tables start as valid+dirty with tag 1 so a missing init sweep would produce false hits.
    logic [19:0]  tag_m   [2][256];
    logic         valid_m [2][256];
    logic         dirty_m [2][256];
    logic         lru_m   [2][256];
    logic [127:0] data_m  [2][256];
    logic [19:0]  rtag_q  [2];
    logic         rvalid_q[2], rdirty_q[2], rlru_q[2];
    logic [127:0] rdata_q [2];
    logic         tag_en[2], valid_en[2], dirty_en[2], lru_en[2];
    logic [3:0]   den[2];
    bit           model_init = 1'b0;

    always_comb begin
        tag_en[0] = w0_tag_en_o;     tag_en[1] = w1_tag_en_o;
        valid_en[0] = w0_valid_en_o; valid_en[1] = w1_valid_en_o;
        dirty_en[0] = w0_dirty_en_o; dirty_en[1] = w1_dirty_en_o;
        lru_en[0] = w0_lru_en_o;     lru_en[1] = w1_lru_en_o;
        den[0] = w0_data_en_o;       den[1] = w1_data_en_o;
    end

    assign w0_rd_tag_i = rtag_q[0];   assign w1_rd_tag_i = rtag_q[1];
    assign w0_rd_valid_i = rvalid_q[0]; assign w1_rd_valid_i = rvalid_q[1];
    assign w0_rd_dirty_i = rdirty_q[0]; assign w1_rd_dirty_i = rdirty_q[1];
    assign w0_rd_lru_i = rlru_q[0];   assign w1_rd_lru_i = rlru_q[1];
    assign w0_rd_data_i = rdata_q[0]; assign w1_rd_data_i = rdata_q[1];

    always @(posedge clk) begin
        if (!model_init) begin
            for (int w = 0; w < 2; w++) begin
                for (int i = 0; i < 256; i++) begin
                    tag_m[w][i]   <= 20'h1;
                    valid_m[w][i] <= 1'b1;
                    dirty_m[w][i] <= 1'b1;
                    lru_m[w][i]   <= 1'b0;
                    data_m[w][i]  <= '0;
                end
            end
            model_init <= 1'b1;
        end else begin
            for (int w = 0; w < 2; w++) begin
                rtag_q[w]   <= tag_m[w][index_o];
                rvalid_q[w] <= valid_m[w][index_o];
                rdirty_q[w] <= dirty_m[w][index_o];
                rlru_q[w]   <= lru_m[w][index_o];
                rdata_q[w]  <= data_m[w][index_o];
                if (tag_en[w])   tag_m[w][index_o]   <= wr_tag_o;
                if (valid_en[w]) valid_m[w][index_o] <= wr_valid_o;
                if (dirty_en[w]) dirty_m[w][index_o] <= wr_dirty_o;
                if (lru_en[w])   lru_m[w][index_o]   <= wr_lru_o;
                for (int b = 0; b < 4; b++) begin
                    if (den[w][b]) data_m[w][index_o][b*32 +: 32] <= wr_data_o[b*32 +: 32];
                end
            end
        end
    end

    // Main memory: lines never written back read as a fixed address pattern.
    logic [127:0] main_mem [logic [31:0]];

    function automatic logic [127:0] pat(input logic [31:0] a);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) begin
            l[i*32 +: 32] = 32'hC0DE0000 | {16'h0, a[15:4], 4'h0} | 32'(i * 4);
        end
        return l;
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        if (main_mem.exists(a)) return main_mem[a];
        return pat(a);
    endfunction

    typedef struct {
        logic          we;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        int            ack_delay;
        logic          chk_rd;
        logic [31:0]   rdata;
        int            lat;
        logic          wb;
        logic [31:0]   wb_addr;
        logic [127:0]  wb_data;
        logic          rf;
        logic [31:0]   rf_addr;
        logic [3:0]    den0;
        logic [3:0]    den1;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic applyStimulus(input vec_t v, input int id);
        int k, cyc, wb_cnt;
        logic got_done, wb_seen, rf_seen, wb_stable;
        logic [31:0] rdata, wb_addr, rf_addr;
        logic [127:0] wb_data;
        logic [3:0] d0, d1;
        got_done = 0; wb_seen = 0; rf_seen = 0; wb_stable = 1; wb_cnt = 0;
        rdata = '0; wb_addr = '0; rf_addr = '0; wb_data = '0; d0 = '0; d1 = '0; cyc = 0;
        for (k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (cpu_ready_o) break;
        end
        if (k == 50) begin
            checkOutput($sformatf("v%0d_ready_timeout", id), 0, 1);
            return;
        end
        cpu_req_i = 1'b1; cpu_we_i = v.we; cpu_addr_i = v.addr; cpu_wdata_i = v.wdata;
        for (cyc = 2; cyc < 80; cyc++) begin
            @(negedge clk);
            cpu_req_i = 1'b0; mem_rd_valid_i = 1'b0; mem_wr_ack_i = 1'b0;
            #1;
            if (cpu_done_o) begin
                got_done = 1; rdata = cpu_rdata_o; d0 = w0_data_en_o; d1 = w1_data_en_o;
                break;
            end
            if (mem_wr_req_o) begin
                if (!wb_seen) begin
                    wb_addr = mem_wr_addr_o; wb_data = mem_wr_data_o;
                end else if (mem_wr_addr_o !== wb_addr || mem_wr_data_o !== wb_data) begin
                    wb_stable = 0;
                end
                wb_seen = 1; wb_cnt++;
                if (wb_cnt > v.ack_delay) begin
                    mem_wr_ack_i = 1'b1;
                    main_mem[mem_wr_addr_o] = mem_wr_data_o;
                end
            end
            if (mem_rd_req_o) begin
                rf_seen = 1; rf_addr = mem_rd_addr_o;
                mem_rd_data_i = mem_line(mem_rd_addr_o);
                mem_rd_valid_i = 1'b1;
            end
        end
        checkOutput($sformatf("v%0d_done", id), got_done, 1);
        if (!got_done) return;
        if (v.chk_rd) checkOutput($sformatf("v%0d_rdata", id), rdata, v.rdata);
        checkOutput($sformatf("v%0d_latency", id), cyc, v.lat);
        checkOutput($sformatf("v%0d_wb_req", id), wb_seen, v.wb);
        if (v.wb) begin
            checkOutput($sformatf("v%0d_wb_addr", id), wb_addr, v.wb_addr);
            checkOutput($sformatf("v%0d_wb_data", id), wb_data, v.wb_data);
            checkOutput($sformatf("v%0d_wb_stable", id), wb_stable, 1);
        end
        checkOutput($sformatf("v%0d_rd_req", id), rf_seen, v.rf);
        if (v.rf) checkOutput($sformatf("v%0d_rd_addr", id), rf_addr, v.rf_addr);
        checkOutput($sformatf("v%0d_w0_data_en", id), d0, v.den0);
        checkOutput($sformatf("v%0d_w1_data_en", id), d1, v.den1);
    endtask

    task automatic releaseResetAndSweep(input string name);
        int cyc, good;
        cyc = 0; good = 0;
        @(negedge clk);
        rst = 1'b0;
        while (cyc < 300) begin
            #1;
            if (cpu_ready_o) break;
            if (index_o == cyc[7:0] && w0_valid_en_o && w1_valid_en_o && w0_dirty_en_o &&
                w1_dirty_en_o && w0_lru_en_o && w1_lru_en_o && !wr_valid_o && !wr_dirty_o &&
                !wr_lru_o && !w0_tag_en_o && !w1_tag_en_o && w0_data_en_o == 4'b0 &&
                w1_data_en_o == 4'b0 && !cpu_done_o)
                good++;
            cyc++;
            @(negedge clk);
        end
        checkOutput({name, "_ready_cycles"}, cyc, 256);
        checkOutput({name, "_sweep"}, good, 256);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int k, done_cnt;
        //            we    addr          wdata         ack  chk   rdata         lat wb    wb_addr       wb_data                                  rf    rf_addr       den0     den1
        vecs[0]  = '{1'b0, 32'h0000_1004, 32'h0,        0, 1'b1, 32'hC0DE1004, 4, 1'b0, 32'h0,        128'h0,                                  1'b1, 32'h0000_1000, 4'b1111, 4'b0000};
        vecs[1]  = '{1'b0, 32'h0000_1004, 32'h0,        0, 1'b1, 32'hC0DE1004, 2, 1'b0, 32'h0,        128'h0,                                  1'b0, 32'h0,         4'b0000, 4'b0000};
        vecs[2]  = '{1'b1, 32'h0000_1008, 32'hDEADBEEF, 0, 1'b0, 32'h0,        2, 1'b0, 32'h0,        128'h0,                                  1'b0, 32'h0,         4'b0100, 4'b0000};
        vecs[3]  = '{1'b0, 32'h0000_1008, 32'h0,        0, 1'b1, 32'hDEADBEEF, 2, 1'b0, 32'h0,        128'h0,                                  1'b0, 32'h0,         4'b0000, 4'b0000};
        vecs[4]  = '{1'b1, 32'h0000_2000, 32'h11112222, 0, 1'b1, 32'h11112222, 4, 1'b0, 32'h0,        128'h0,                                  1'b1, 32'h0000_2000, 4'b0000, 4'b1111};
        vecs[5]  = '{1'b1, 32'h0000_300C, 32'h33334444, 0, 1'b1, 32'h33334444, 5, 1'b1, 32'h0000_1000, 128'hC0DE100C_DEADBEEF_C0DE1004_C0DE1000, 1'b1, 32'h0000_3000, 4'b1111, 4'b0000};
        vecs[6]  = '{1'b0, 32'h0000_4000, 32'h0,        5, 1'b1, 32'hC0DE4000, 10, 1'b1, 32'h0000_2000, 128'hC0DE200C_C0DE2008_C0DE2004_11112222, 1'b1, 32'h0000_4000, 4'b0000, 4'b1111};
        vecs[7]  = '{1'b0, 32'h0000_1000, 32'h0,        2, 1'b1, 32'hC0DE1000, 7, 1'b1, 32'h0000_3000, 128'h33334444_C0DE3008_C0DE3004_C0DE3000, 1'b1, 32'h0000_1000, 4'b1111, 4'b0000};
        vecs[8]  = '{1'b0, 32'h0000_1008, 32'h0,        0, 1'b1, 32'hDEADBEEF, 2, 1'b0, 32'h0,        128'h0,                                  1'b0, 32'h0,         4'b0000, 4'b0000};
        vecs[9]  = '{1'b0, 32'h0000_5004, 32'h0,        0, 1'b1, 32'hC0DE5004, 4, 1'b0, 32'h0,        128'h0,                                  1'b1, 32'h0000_5000, 4'b0000, 4'b1111};
        vecs[10] = '{1'b1, 32'h0000_1FF0, 32'hCAFEF00D, 0, 1'b1, 32'hCAFEF00D, 4, 1'b0, 32'h0,        128'h0,                                  1'b1, 32'h0000_1FF0, 4'b1111, 4'b0000};
        vecs[11] = '{1'b0, 32'h0000_1FF0, 32'h0,        0, 1'b1, 32'hCAFEF00D, 2, 1'b0, 32'h0,        128'h0,                                  1'b0, 32'h0,         4'b0000, 4'b0000};
        vecs[12] = '{1'b0, 32'h0000_1008, 32'h0,        0, 1'b1, 32'hDEADBEEF, 4, 1'b0, 32'h0,        128'h0,                                  1'b1, 32'h0000_1000, 4'b1111, 4'b0000};
        vecs[13] = '{1'b0, 32'h0000_1004, 32'h0,        0, 1'b1, 32'hC0DE1004, 2, 1'b0, 32'h0,        128'h0,                                  1'b0, 32'h0,         4'b0000, 4'b0000};

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checkOutput("rst_ready", cpu_ready_o, 0);
        checkOutput("rst_mem_reqs", {mem_rd_req_o, mem_wr_req_o}, 2'b00);
        releaseResetAndSweep("init");

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

        // Reset while a refill is outstanding must abort it and restart the sweep.
        for (k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (cpu_ready_o) break;
        end
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_6000;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            cpu_req_i = 1'b0;
            #1;
            if (mem_rd_req_o) break;
        end
        checkOutput("rst_refill_reached", mem_rd_req_o, 1);
        rst = 1'b1;
        done_cnt = 0;
        @(negedge clk); #1;
        checkOutput("rst_rd_req_drop", mem_rd_req_o, 0);
        for (int j = 0; j < 3; j++) begin
            if (cpu_done_o) done_cnt++;
            @(negedge clk); #1;
        end
        checkOutput("rst_no_done", done_cnt, 0);
        releaseResetAndSweep("rerun");

        applyStimulus(vecs[12], 12);
        applyStimulus(vecs[13], 13);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Control FSM for the 2-way, write-back, write-allocate data cache.
- Sits between the core LSU and two cache way instances (way0, way1): drives index/offset and all table write enables, and compares returned tags.
- On a miss it writes back the dirty victim line and refills from memory over a single-beat 128-bit line interface.
- After reset it sweeps every set to clear the valid, dirty and LRU bits.

Parameters:
- IDX_W, 8, index width (256 sets).
- TAG_W, 20, tag width; address = tag[31:12] | index[11:4] | offset[3:0].
- OFF_W, 4, byte offset within a 16-byte (4-word) line.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cpu_req_i  in  1  access request; accepted when cpu_ready_o=1.
- cpu_we_i  in  1  1=store (full word), 0=load.
- cpu_addr_i  in  32  byte address; bits[1:0] ignored.
- cpu_wdata_i  in  32  store data.
- cpu_ready_o  out  1  controller can accept a request this cycle.
- cpu_done_o  out  1  one-cycle completion pulse.
- cpu_rdata_o  out  32  load data, valid with cpu_done_o.
- index_o  out  IDX_W  index to both ways.
- offset_o  out  OFF_W  offset to both ways.
- w0_/w1_ tag_en_o, valid_en_o, dirty_en_o, lru_en_o  out  1 each  per-way table write enables.
- w0_/w1_ data_en_o  out  4 each  per-way bank write enables.
- wr_tag_o  out  TAG_W; wr_valid_o, wr_dirty_o, wr_lru_o  out  1 each; wr_data_o  out  128: write data shared by both ways.
- w0_/w1_ rd_tag_i  in  TAG_W; rd_valid_i, rd_dirty_i, rd_lru_i  in  1 each; rd_data_i  in  128: way read data.
- mem_rd_req_o  out  1  refill request.
- mem_rd_addr_o  out  32  refill address, line-aligned.
- mem_rd_valid_i  in  1  refill line returned.
- mem_rd_data_i  in  128  refill line.
- mem_wr_req_o  out  1  writeback request.
- mem_wr_addr_o  out  32  writeback address.
- mem_wr_data_o  out  128  writeback line.
- mem_wr_ack_i  in  1  writeback accepted.

Behaviour:
- **Way tables:** 1-cycle synchronous read. Index/offset presented in cycle N give data in cycle N+1.
- **Reset:** clk-synchronous, overrides any state including mid-miss.
  - All outputs drop to 0; mem_*_req_o deassert immediately.
  - State goes to INIT with sweep counter 0.
  - No in-flight request is completed.
- **INIT:**
  - index_o = counter; both ways write valid=0, dirty=0, lru=0; tag/data enables stay 0.
  - Counter increments each cycle. At 255 → IDLE, so INIT lasts 256 cycles.
  - cpu_ready_o=0 throughout.
- **IDLE:**
  - cpu_ready_o=1.
  - On cpu_req_i, latch addr/we/wdata, drive index_o/offset_o from cpu_addr_i, and go to LOOKUP.
- **LOOKUP:** hit_w = rd_valid_w & (rd_tag_w == latched tag). Both ways hitting is illegal; way0 wins.
  - Load hit:
    - cpu_done_o=1 this cycle; cpu_rdata_o = word[offset[3:2]] of the hit way.
    - Write lru in both ways (1 if way0 hit, else 0).
    - → IDLE.
  - Store hit:
    - wr_data_o = wdata replicated 4×; data_en = one-hot(offset[3:2]) on the hit way only.
    - Dirty write of 1 on the hit way; lru update as for a load hit.
    - cpu_done_o=1 → IDLE.
  - Miss:
    - Victim = way0 if w0_rd_lru_i=0, else way1.
    - Latch victim tag and data.
    - If victim is valid and dirty → WB, else → REFILL.
- **Throughput:** one request per 2 cycles on a hit.
- **WB:**
  - mem_wr_req_o=1, mem_wr_addr_o = {victim tag, index, 4'b0}, mem_wr_data_o = victim line.
  - Request, address and data are held stable until mem_wr_ack_i.
  - On ack → REFILL; the ack may arrive in the first WB cycle.
- **REFILL:**
  - mem_rd_req_o=1, mem_rd_addr_o = {latched addr[31:4], 4'b0}, held until mem_rd_valid_i.
  - On valid, register the line → FILL.
- **FILL (1 cycle):**
  - Victim way is written with tag = latched tag, valid=1, dirty = latched we.
  - Data = refilled line, with the store word merged in at offset[3:2] when we=1; data_en = 4'b1111.
  - lru points away from the victim (both ways written).
  - cpu_done_o=1; cpu_rdata_o = merged word[offset[3:2]] → IDLE.
- **Default outputs:** every enable is 0 in states that do not name it. cpu_done_o is never asserted outside LOOKUP-hit/FILL.
- **Ignored inputs:** cpu_req_i is ignored while cpu_ready_o=0. mem_rd_valid_i and mem_wr_ack_i are ignored outside REFILL and WB respectively.

Test Plan:
- Reset, then count cycles → cpu_ready_o rises exactly 256 cycles after rst falls; all 256 sets read valid=0.
- Load 0x0000_1004 (cold) → REFILL addr 0x0000_1000. Return line {W3,W2,W1,W0} → cpu_done with W1; reload same address hits in 2 cycles with no mem request.
- Store 0xDEADBEEF to 0x0000_1008 after the fill → bank2 of the hit way only written, dirty=1. A load of 0x0000_1008 then returns 0xDEADBEEF.
- Fill set 0 from both 0x0000_2000 and 0x0000_3000 with a store to each. Then access 0x0000_4000 → WB of the LRU line with the correct address/data, then refill. mem_wr_ack_i is delayed 5 cycles and requests must stay stable.
- Miss to a clean victim → no mem_wr_req_o; the refill is issued directly.
- Assert rst during REFILL → mem_rd_req_o drops next edge, no cpu_done_o, INIT sweep restarts.
